// File: rtl/pulp_io_evt_fifo.sv
// pulp_io_evt_fifo: IO event collector.
// Event pulses are latched as pending. A round-robin arbiter pushes one
// pending event ID per cycle into a small FIFO. The FIFO drains to the SoC
// event unit over a valid/ready stream.
// Optional build macro PULP_IO_EVT_DROP_CNT_EN adds a saturating 16-bit
// counter of dropped events on port drop_cnt_o.
module pulp_io_evt_fifo #(
  parameter int N_EVT = 128,
  parameter int DEPTH = 8,
  parameter int ID_W  = 8
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_ni,
  input  logic [N_EVT-1:0]         evt_i,
  input  logic [N_EVT-1:0]         evt_mask_i,
  output logic                     evt_valid_o,
  output logic [ID_W-1:0]          evt_data_o,
  input  logic                     evt_ready_i,
  output logic                     ovf_o,
  input  logic                     ovf_clr_i,
  output logic                     drop_o,
`ifdef PULP_IO_EVT_DROP_CNT_EN
  output logic [15:0]              drop_cnt_o,
`endif
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int PTR_W = $clog2(N_EVT);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [PTR_W:0]   N_EVT_EXT = (PTR_W+1)'(N_EVT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_EVT - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);

  logic [N_EVT-1:0] pending;
  logic [N_EVT-1:0] evt_set;
  logic [N_EVT-1:0] grant_vec;
  logic [N_EVT-1:0] drop_vec;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             push;
  logic             pop;
  logic             push_ok;

  assign evt_set  = evt_i & evt_mask_i;
  assign pop      = evt_valid_o & evt_ready_i;
  assign push_ok  = (fifo_cnt != FULL_CNT) | pop;
  assign push     = grant_vld;
  assign drop_vec = evt_set & pending & ~grant_vec;

  assign evt_valid_o = (fifo_cnt != '0);
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;
  assign fifo_cnt_o  = fifo_cnt;

  // Round-robin scan starting at rr_ptr; first pending index wins when the FIFO can take it
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (push_ok) begin
      for (int k = 0; k < N_EVT; k++) begin
        scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (scan_sum >= N_EVT_EXT) begin
          scan_sum = scan_sum - N_EVT_EXT;
        end
        scan_idx = scan_sum[PTR_W-1:0];
        if (!grant_vld && pending[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // Pending bits: a new event in the grant cycle re-arms the bit instead of being lost
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_vec) | evt_set;
    end
  end

  // Arbiter pointer moves just past the granted index so every source gets a turn
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // FIFO storage needs no reset because the output is forced to zero when empty
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= ID_W'(grant_idx);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Drop reporting: one-cycle pulse plus a sticky flag where a new drop beats a clear
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      drop_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      drop_o <= |drop_vec;
      if (|drop_vec) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

`ifdef PULP_IO_EVT_DROP_CNT_EN
  logic [16:0] drop_amt;
  logic [16:0] drop_sum;

  assign drop_amt = 17'($countones(drop_vec));
  assign drop_sum = {1'b0, drop_cnt_o} + drop_amt;

  // Saturating drop counter; a clear restarts counting from this cycle's drops
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      drop_cnt_o <= '0;
    end else if (ovf_clr_i) begin
      drop_cnt_o <= drop_amt[16] ? 16'hFFFF : drop_amt[15:0];
    end else begin
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
